alu_share_ctrl: RTL and testbench

- Arbitrates a single shared ALU between two requesters and sequences each operation through a registered ALU datapath held inside the block.
- Round-robin fairness; per-requester req/ack handshake; one operation in flight at a time.
- Sits between the two command sources (e.g. a test sequencer and a switch/key front end) and the result display logic.

---
 rtl/alu_share_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//
// Shares one registered ALU between two requesters. A round-robin arbiter
// picks a requester in IDLE, its opcode/operands are captured, the ALU result
// is registered in EXEC, and a one-cycle ack is returned to that requester in
// DONE. Exactly one operation is in flight at a time (one op per 3 cycles).
//
// Optional feature (macro ALU_SHARE_STATS_EN): adds saturating 16-bit
// per-requester completed-operation counters op_cnt0/op_cnt1.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   req[1:0]  per-requester operation pending
//   cmd0/a0/b0, cmd1/a1/b1   opcode and operands of each requester
//   ack[1:0]  one-cycle completion pulse to the requester served
//   result    ALU result, valid while ack != 0 and held afterwards
//   overflow  carry-out for add/sub, 0 otherwise (same timing as result)
//   busy      high while in EXEC or DONE
//   grant_id  requester currently or last served
//   op_cnt0/op_cnt1  (ALU_SHARE_STATS_EN only) completed-op counters
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [2:0]       cmd0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [2:0]       cmd1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       ack,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             busy,
    output logic             grant_id
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [15:0]      op_cnt0,
    output logic [15:0]      op_cnt1
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    state_t           state_q, state_d;
    logic [2:0]       op_cmd_q, op_cmd_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             grant_id_q, grant_id_d;
    logic             rr_last_q, rr_last_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic [1:0]       ack_q, ack_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] alu_res_s;
    logic             alu_ovf_s;
    logic [WIDTH:0]   alu_sum_s;
    logic [WIDTH-1:0] neg_b_s;
    logic             gsel_s;

    // ALU datapath: works only on the captured operands, never on live inputs
    always_comb begin
        alu_sum_s = {1'b0, ZERO_W};
        neg_b_s   = (~op_b_q) + ONE_W;
        alu_res_s = ZERO_W;
        alu_ovf_s = 1'b0;
        case (op_cmd_q)
            3'b000: begin
                alu_sum_s = {1'b0, op_a_q} + {1'b0, op_b_q};
                alu_res_s = alu_sum_s[WIDTH-1:0];
                alu_ovf_s = alu_sum_s[WIDTH];
            end
            3'b001: begin
                // Subtract as a + (-b); b == 0 yields -b == 0, so no carry.
                alu_sum_s = {1'b0, op_a_q} + {1'b0, neg_b_s};
                alu_res_s = alu_sum_s[WIDTH-1:0];
                alu_ovf_s = alu_sum_s[WIDTH];
            end
            3'b010:  alu_res_s = ~op_a_q;
            3'b011:  alu_res_s = op_a_q & op_b_q;
            3'b100:  alu_res_s = op_a_q | op_b_q;
            3'b101:  alu_res_s = op_a_q ^ op_b_q;
            3'b110:  alu_res_s = ($signed(op_a_q) < $signed(op_b_q)) ? ONE_W : ZERO_W;
            3'b111:  alu_res_s = (op_a_q == op_b_q) ? ONE_W : ZERO_W;
            default: alu_res_s = ZERO_W;
        endcase
    end

    // Round-robin pick: on a tie, serve the requester that was not served last
    always_comb begin
        if (req == 2'b11) begin
            gsel_s = ~rr_last_q;
        end else begin
            gsel_s = req[1];
        end
    end

    // Next-state and next-output logic for the IDLE -> EXEC -> DONE sequence
    always_comb begin
        state_d    = state_q;
        op_cmd_d   = op_cmd_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        grant_id_d = grant_id_q;
        rr_last_d  = rr_last_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        ack_d      = 2'b00;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    grant_id_d = gsel_s;
                    op_cmd_d   = gsel_s ? cmd1 : cmd0;
                    op_a_d     = gsel_s ? a1   : a0;
                    op_b_d     = gsel_s ? b1   : b0;
                    busy_d     = 1'b1;
                    state_d    = ST_EXEC;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_EXEC: begin
                result_d   = alu_res_s;
                overflow_d = alu_ovf_s;
                // ack is registered so it is high exactly during DONE
                ack_d      = grant_id_q ? 2'b10 : 2'b01;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                rr_last_d  = grant_id_q;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_cmd_q   <= 3'b000;
            op_a_q     <= ZERO_W;
            op_b_q     <= ZERO_W;
            grant_id_q <= 1'b0;
            rr_last_q  <= 1'b1;
            result_q   <= ZERO_W;
            overflow_q <= 1'b0;
            ack_q      <= 2'b00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_cmd_q   <= op_cmd_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            grant_id_q <= grant_id_d;
            rr_last_q  <= rr_last_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign result   = result_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

`ifdef ALU_SHARE_STATS_EN
    logic [15:0] op_cnt0_q, op_cnt0_d;
    logic [15:0] op_cnt1_q, op_cnt1_d;

    // Saturating per-requester counters, bumped on the edge leaving DONE
    always_comb begin
        op_cnt0_d = op_cnt0_q;
        op_cnt1_d = op_cnt1_q;
        if (state_q == ST_DONE) begin
            if (grant_id_q == 1'b0) begin
                if (op_cnt0_q != 16'hFFFF) begin
                    op_cnt0_d = op_cnt0_q + 16'd1;
                end else begin
                    op_cnt0_d = op_cnt0_q;
                end
            end else begin
                if (op_cnt1_q != 16'hFFFF) begin
                    op_cnt1_d = op_cnt1_q + 16'd1;
                end else begin
                    op_cnt1_d = op_cnt1_q;
                end
            end
        end else begin
            op_cnt0_d = op_cnt0_q;
            op_cnt1_d = op_cnt1_q;
        end
    end

    // Counter flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt0_q <= 16'd0;
            op_cnt1_q <= 16'd0;
        end else begin
            op_cnt0_q <= op_cnt0_d;
            op_cnt1_q <= op_cnt1_d;
        end
    end

    assign op_cnt0 = op_cnt0_q;
    assign op_cnt1 = op_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_share_ctrl: directed self-checking bench for alu_share_ctrl (WIDTH=4).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_share_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [2:0] cmd0, cmd1;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] ack;
    logic [3:0] result;
    logic       overflow;
    logic       busy;
    logic       grant_id;
`ifdef ALU_SHARE_STATS_EN
    logic [15:0] op_cnt0, op_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    alu_share_ctrl #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .cmd0     (cmd0),
        .a0       (a0),
        .b0       (b0),
        .cmd1     (cmd1),
        .a1       (a1),
        .b1       (b1),
        .ack      (ack),
        .result   (result),
        .overflow (overflow),
        .busy     (busy),
        .grant_id (grant_id)
`ifdef ALU_SHARE_STATS_EN
        ,
        .op_cnt0  (op_cnt0),
        .op_cnt1  (op_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ack must never be 11 and never be high outside a busy (DONE) cycle
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert ((ack !== 2'b11) && ((ack === 2'b00) || (busy === 1'b1))) else begin
                errors++;
                $error("FAIL ack_legal observed ack=%b busy=%b expected ack one-hot within busy", ack, busy);
            end
        end
    end

    // One op from an idle block: grant, EXEC, DONE(ack), then back to IDLE.
    task automatic run_op(input string tag, input int rq, input logic [2:0] cmd,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] er, input logic eo);
        logic [1:0] exp_ack;
        exp_ack = (rq == 1) ? 2'b10 : 2'b01;
        if (rq == 1) begin
            cmd1 = cmd; a1 = a; b1 = b; req[1] = 1'b1;
        end else begin
            cmd0 = cmd; a0 = a; b0 = b; req[0] = 1'b1;
        end
        @(negedge clk);                       // grant edge passed: EXEC
        check({tag, "_exec_ack"}, {14'd0, ack}, {14'd0, 2'b00});
        check({tag, "_exec_busy"}, {15'd0, busy}, 16'd1);
        check({tag, "_gid"}, {15'd0, grant_id}, rq[15:0]);
        // operands become don't-care once captured
        a0 = 4'h0; b0 = 4'h0; a1 = 4'h0; b1 = 4'h0; cmd0 = 3'b111; cmd1 = 3'b111;
        @(negedge clk);                       // DONE
        check({tag, "_ack"}, {14'd0, ack}, {14'd0, exp_ack});
        check({tag, "_res"}, {12'd0, result}, {12'd0, er});
        check({tag, "_ovf"}, {15'd0, overflow}, {15'd0, eo});
        req = 2'b00;
        @(negedge clk);                       // IDLE again
        check({tag, "_ack_clr"}, {14'd0, ack}, {14'd0, 2'b00});
        check({tag, "_idle_busy"}, {15'd0, busy}, 16'd0);
        check({tag, "_res_hold"}, {12'd0, result}, {12'd0, er});
    endtask

    initial begin
        rst = 1'b1; req = 2'b00;
        cmd0 = 3'b000; a0 = 4'h0; b0 = 4'h0;
        cmd1 = 3'b000; a1 = 4'h0; b1 = 4'h0;
        #1;
        check("rst_ack", {14'd0, ack}, 16'd0);
        check("rst_res", {12'd0, result}, 16'd0);
        check("rst_ovf", {15'd0, overflow}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_gid", {15'd0, grant_id}, 16'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // add / subtract boundaries
        run_op("add_7_3",  0, 3'b000, 4'h7, 4'h3, 4'hA, 1'b0);
        run_op("sub_3_5",  0, 3'b001, 4'h3, 4'h5, 4'hE, 1'b0);
        run_op("sub_5_3",  0, 3'b001, 4'h5, 4'h3, 4'h2, 1'b1);
        run_op("sub_b0",   1, 3'b001, 4'h7, 4'h0, 4'h7, 1'b0);
        run_op("add_carry",1, 3'b000, 4'hF, 4'h1, 4'h0, 1'b1);

        // logic and compare ops
        run_op("slt_e_2",  1, 3'b110, 4'hE, 4'h2, 4'h1, 1'b0);
        run_op("slt_2_e",  0, 3'b110, 4'h2, 4'hE, 4'h0, 1'b0);
        run_op("eq_9_9",   1, 3'b111, 4'h9, 4'h9, 4'h1, 1'b0);
        run_op("eq_9_8",   0, 3'b111, 4'h9, 4'h8, 4'h0, 1'b0);
        run_op("not_5",    0, 3'b010, 4'h5, 4'h0, 4'hA, 1'b0);
        run_op("and",      1, 3'b011, 4'hC, 4'hA, 4'h8, 1'b0);
        run_op("or",       0, 3'b100, 4'hC, 4'hA, 4'hE, 1'b0);
        run_op("xor",      1, 3'b101, 4'hC, 4'hA, 4'h6, 1'b0);

        // round-robin with both requesters held high, from reset state
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmd0 = 3'b000; a0 = 4'h1; b0 = 4'h1;   // 2
        cmd1 = 3'b011; a1 = 4'hF; b1 = 4'h6;   // 6
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_gid", {15'd0, grant_id}, (i % 2 == 1) ? 16'd1 : 16'd0);
            check("rr_exec_ack", {14'd0, ack}, 16'd0);
            @(negedge clk);
            check("rr_ack", {14'd0, ack}, (i % 2 == 1) ? 16'h2 : 16'h1);
            check("rr_res", {12'd0, result}, (i % 2 == 1) ? 16'h6 : 16'h2);
            @(negedge clk);
            check("rr_idle_ack", {14'd0, ack}, 16'd0);
        end
        req = 2'b00;
        @(negedge clk);

        // reset during EXEC for requester 1
        cmd1 = 3'b000; a1 = 4'h6; b1 = 4'h5;
        req = 2'b10;
        @(negedge clk);
        check("mid_gid", {15'd0, grant_id}, 16'd1);
        rst = 1'b1;
        #1;
        check("mid_ack", {14'd0, ack}, 16'd0);
        check("mid_res", {12'd0, result}, 16'd0);
        check("mid_busy", {15'd0, busy}, 16'd0);
        check("mid_gid_rst", {15'd0, grant_id}, 16'd0);
        @(negedge clk);
        check("mid_ack_held", {14'd0, ack}, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_gid", {15'd0, grant_id}, 16'd1);
        check("post_busy", {15'd0, busy}, 16'd1);
        @(negedge clk);
        check("post_ack", {14'd0, ack}, 16'h2);
        check("post_res", {12'd0, result}, 16'hB);
        check("post_ovf", {15'd0, overflow}, 16'd0);
        req = 2'b00;
        @(negedge clk);

`ifdef ALU_SHARE_STATS_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) run_op("cnt0", 0, 3'b000, 4'h1, 4'h2, 4'h3, 1'b0);
        for (int i = 0; i < 3; i++) run_op("cnt1", 1, 3'b101, 4'h1, 4'h2, 4'h3, 1'b0);
        check("op_cnt0", op_cnt0, 16'd5);
        check("op_cnt1", op_cnt1, 16'd3);
        rst = 1'b1;
        #1;
        check("op_cnt0_rst", op_cnt0, 16'd0);
        check("op_cnt1_rst", op_cnt1, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
